// File: rtl/hilo_div_ctrl.sv
// Sequences DIVU/DIV/MTHI/MTLO between execute and the iterative divider and owns HI/LO.
// Build option: define HILO_SIGNED_DIV_EN to compile in signed DIV (op 01) magnitude/sign fix-up.
module hilo_div_ctrl #(
    parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    // state  | meaning
    // IDLE   | accept MTHI/MTLO or a divide request
    // LAUNCH | div_start high, operands presented to the divider
    // WAIT   | divider running, hold until div_busy drops
    // FIX    | apply sign fix-up and write HI/LO
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIX} state_t;

    state_t      state;
    logic        div_req;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // A zero divisor is dropped entirely so HI/LO keep their previous values.
    assign div_req = op_valid && !op[1] && (rt_val != 32'd0);

`ifdef HILO_SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;
    logic rs_neg;
    logic rt_neg;

    assign rs_neg = op[0] & rs_val[31];
    assign rt_neg = op[0] & rt_val[31];
    // INT_MIN negates to itself, which is the correct unsigned magnitude.
    assign rs_mag = rs_neg ? (~rs_val + 32'd1) : rs_val;
    assign rt_mag = rt_neg ? (~rt_val + 32'd1) : rt_val;
    assign q_fix  = neg_q ? (~div_q + 32'd1) : div_q;
    assign r_fix  = neg_r ? (~div_r + 32'd1) : div_r;
`else
    assign rs_mag = rs_val;
    assign rt_mag = rt_val;
    assign q_fix  = div_q;
    assign r_fix  = div_r;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            hi           <= HILO_RESET;
            lo           <= HILO_RESET;
            div_start    <= 1'b0;
            stall        <= 1'b0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
`ifdef HILO_SIGNED_DIV_EN
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && op == 2'b10) begin
                        hi <= rs_val;
                    end else if (op_valid && op == 2'b11) begin
                        lo <= rs_val;
                    end else if (div_req) begin
                        div_dividend <= rs_mag;
                        div_divisor  <= rt_mag;
                        div_start    <= 1'b1;
                        stall        <= 1'b1;
                        state        <= LAUNCH;
`ifdef HILO_SIGNED_DIV_EN
                        neg_q        <= rs_neg ^ rt_neg;
                        neg_r        <= rs_neg;
`endif
                    end
                end
                LAUNCH: begin
                    div_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!div_busy) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= q_fix;
                    hi    <= r_fix;
                    stall <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl with a behavioural 32-cycle divider; expectations follow HILO_SIGNED_DIV_EN.
module tb_hilo_div_ctrl;

    logic        clock;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    hilo_div_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .op_valid     (op_valid),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_q        (div_q),
        .div_r        (div_r),
        .div_busy     (div_busy),
        .hi           (hi),
        .lo           (lo),
        .stall        (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Divider model: busy for 32 cycles after sampling div_start; results appear only as busy falls.
    int          div_cnt;
    logic [31:0] dvd_l;
    logic [31:0] dvs_l;
    always @(posedge clock) begin
        if (reset) begin
            div_busy <= 1'b0;
            div_cnt  <= 0;
            div_q    <= 32'd0;
            div_r    <= 32'd0;
        end else if (div_start) begin
            div_busy <= 1'b1;
            div_cnt  <= 32;
            dvd_l    <= div_dividend;
            dvs_l    <= div_divisor;
            div_q    <= 32'hA5A5_A5A5;
            div_r    <= 32'h5A5A_5A5A;
        end else if (div_busy) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                div_busy <= 1'b0;
                div_q    <= (dvs_l == 32'd0) ? 32'hFFFF_FFFF : dvd_l / dvs_l;
                div_r    <= (dvs_l == 32'd0) ? dvd_l : dvd_l % dvs_l;
            end
        end
    end

    int start_total;
    always @(posedge clock) begin
        if (div_start) start_total <= start_total + 1;
    end

    int n_pass;
    int n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stall;
        int          exp_starts;
        logic [31:0] exp_dvd;
        logic [31:0] exp_dvs;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    int          stall_cycles;
    int          starts;
    logic [31:0] seen_dvd;
    logic [31:0] seen_dvs;

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        rs_val   = 32'h0BAD_F00D;
        rt_val   = 32'h0;
        stall_cycles = 0;
        starts       = 0;
        seen_dvd     = 32'hx;
        seen_dvs     = 32'hx;
        for (int i = 0; i < 100; i++) begin
            if (!stall) break;
            stall_cycles++;
            if (div_start) begin
                starts++;
                seen_dvd = div_dividend;
                seen_dvs = div_divisor;
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        start_total = 0;
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 2'b00;
        rs_val   = 32'h0;
        rt_val   = 32'h0;

        vecs[0] = '{"mthi",      2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0,         0, 0, 32'h0, 32'h0};
        vecs[1] = '{"mtlo",      2'b11, 32'hDEAD_BEEF, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0};
        vecs[2] = '{"divu_100_7",2'b00, 32'd100,       32'd7, 32'd2,         32'd14,        35, 1, 32'd100, 32'd7};
        vecs[3] = '{"divu_rt0",  2'b00, 32'd5,         32'd0, 32'd2,         32'd14,        0, 0, 32'h0, 32'h0};
        vecs[4] = '{"divu_max16",2'b00, 32'hFFFF_FFFF, 32'h10, 32'hF,        32'h0FFF_FFFF, 35, 1, 32'hFFFF_FFFF, 32'h10};
`ifdef HILO_SIGNED_DIV_EN
        vecs[5] = '{"div_m7_2",  2'b01, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, 1, 32'd7, 32'd2};
        vecs[6] = '{"div_min_m1",2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 35, 1, 32'h8000_0000, 32'd1};
        vecs[7] = '{"div_7_m2",  2'b01, 32'd7,         32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 35, 1, 32'd7, 32'd2};
        vecs[8] = '{"div_rt0",   2'b01, 32'hFFFF_FFF0, 32'd0, 32'd1,         32'hFFFF_FFFD, 0, 0, 32'h0, 32'h0};
`else
        vecs[5] = '{"div_m7_2",  2'b01, 32'hFFFF_FFF9, 32'd2, 32'd1,         32'h7FFF_FFFC, 35, 1, 32'hFFFF_FFF9, 32'd2};
        vecs[6] = '{"div_min_m1",2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 35, 1, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[7] = '{"div_7_m2",  2'b01, 32'd7,         32'hFFFF_FFFE, 32'd7, 32'h0,         35, 1, 32'd7, 32'hFFFF_FFFE};
        vecs[8] = '{"div_rt0",   2'b01, 32'hFFFF_FFF0, 32'd0, 32'd7,         32'h0,         0, 0, 32'h0, 32'h0};
`endif

        repeat (3) @(posedge clock);
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_start", {31'd0, div_start}, 32'd0);
        chk("rst_dvd", div_dividend, 32'h0);
        chk("rst_dvs", div_divisor, 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("idle_no_start", start_total, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);

        for (int v = 0; v < NV; v++) begin
            run_op(vecs[v].op, vecs[v].rs, vecs[v].rt);
            chk({vecs[v].name, "_stall"}, stall_cycles, vecs[v].exp_stall);
            chk({vecs[v].name, "_starts"}, starts, vecs[v].exp_starts);
            chk({vecs[v].name, "_hi"}, hi, vecs[v].exp_hi);
            chk({vecs[v].name, "_lo"}, lo, vecs[v].exp_lo);
            if (vecs[v].exp_starts == 1) begin
                chk({vecs[v].name, "_dvd"}, seen_dvd, vecs[v].exp_dvd);
                chk({vecs[v].name, "_dvs"}, seen_dvs, vecs[v].exp_dvs);
            end
            repeat (2) @(posedge clock);
            #1;
        end

        // op_valid while stalled must be ignored.
        run_op(2'b10, 32'h0000_0001, 32'h0);
        op_valid = 1'b1;
        op       = 2'b00;
        rs_val   = 32'd50;
        rt_val   = 32'd3;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        op_valid = 1'b1;
        op       = 2'b11;
        rs_val   = 32'hCAFE_0000;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        for (int i = 0; i < 60 && stall; i++) begin
            @(posedge clock);
            #1;
        end
        chk("busy_ignore_lo", lo, 32'd16);
        chk("busy_ignore_hi", hi, 32'd2);
        chk("busy_ignore_stall", {31'd0, stall}, 32'd0);

        // Reset at E10 of a DIVU 50/3.
        op_valid = 1'b1;
        op       = 2'b00;
        rs_val   = 32'd50;
        rt_val   = 32'd3;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_start", {31'd0, div_start}, 32'd0);
        starts = start_total;
        repeat (50) @(posedge clock);
        #1;
        chk("post_rst_hi", hi, 32'h0);
        chk("post_rst_lo", lo, 32'h0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_nostart", start_total, starts);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
